intersection_scheduler: RTL and testbench
=========================================

// Module: intersection_scheduler
// PURPOSE
//  Sequences a two-way intersection (NS and EW approaches), one red/yellow/green
//  lamp set per approach, plus a shared pedestrian crossing phase.
//  Sits above the single-approach traffic_controller timing.
//  Shares the green between competing approaches using:
//  - car-presence sensors: rest-in-green
//  - a latched pedestrian request: early gap-out after a minimum green
// PARAMETERS
//  GREEN_TIME    25  max green cycles while the opposite approach has demand
//  MIN_GREEN     10  min green cycles before a pedestrian gap-out (<= GREEN_TIME)
//  YELLOW_TIME   5   yellow cycles
//  ALL_RED_TIME  2   all-red clearance cycles
//  WALK_TIME     8   walk-lamp cycles in the pedestrian phase
//  Constraints: all values in 1..255 (8-bit phase timer).
// PORTS
//  clk           in   1  rising-edge clock
//  reset         in   1  synchronous, active-high
//  ns_car        in   1  car waiting on the NS approach (level)
//  ew_car        in   1  car waiting on the EW approach (level)
//  ped_req       in   1  pedestrian button (pulse or level); latched
//  ns_red        out  1  NS red lamp
//  ns_yellow     out  1  NS yellow lamp
//  ns_green      out  1  NS green lamp
//  ew_red        out  1  EW red lamp
//  ew_yellow     out  1  EW yellow lamp
//  ew_green      out  1  EW green lamp
//  walk          out  1  pedestrian walk lamp
//  ped_ack       out  1  1-cycle pulse: pedestrian request accepted
//  phase         out  3  current state encoding (debug)
// BEHAVIOUR
//  - States (phase): 0 NS_GREEN, 1 NS_YELLOW, 2 CLR_NS, 3 EW_GREEN, 4 EW_YELLOW,
//    5 CLR_EW, 6 PED_WALK.
//  - Lamps are a Moore decode of the state register.
//  - Exactly one lamp per approach is on; every state other than *_GREEN and
//    *_YELLOW shows all red.
//  - Phase timer: 8 bits, cleared on every state change. It increments each
//    cycle and saturates at 255.
//  - A state of length N exits when timer == N-1, so it lasts exactly N cycles.
//  - Reset: state CLR_EW, timer 0, ped_pending 0.
//    Outputs during reset: both reds = 1, all other lamps 0, walk 0, ped_ack 0.
//    Reset mid-operation takes effect on the next edge and overrides all other events.
//  - Green exit, where X = this approach and Y = the opposite approach.
//    From X_GREEN go to X_YELLOW when either condition holds:
//    a) ped_pending && timer >= MIN_GREEN-1
//    b) timer >= GREEN_TIME-1 && (Y_car || ped_pending)
//  - With no opposite demand, X_GREEN rests indefinitely (timer saturates).
//  - X_YELLOW runs for YELLOW_TIME cycles, then goes to CLR_X.
//  - CLR_X runs for ALL_RED_TIME cycles, then:
//    - PED_WALK if ped_pending;
//    - otherwise the opposite green: CLR_NS goes to EW_GREEN, CLR_EW goes to NS_GREEN.
//  - PED_WALK lasts WALK_TIME + ALL_RED_TIME cycles with all red.
//    walk = 1 for the first WALK_TIME cycles, 0 for the trailing clearance.
//    Exit goes to the green opposite the last served vehicle phase,
//    held in 1-bit reg last_dir.
//  - ped_pending is set by ped_req in any state except PED_WALK, where ped_req is ignored.
//  - On the CLR_X -> PED_WALK transition:
//    - ped_pending clears;
//    - ped_ack pulses on the first PED_WALK cycle.
//  - ped_req held high through PED_WALK re-latches only after PED_WALK exits.
//  - Sensors are sampled every cycle; no latching.
//    A car that leaves before the green limit cancels case (b).
// TESTING (defaults; cycle 0 = first edge after reset deassert)
//  1. ns_car=ew_car=1, no ped: CLR_EW cycles 0-1; NS_GREEN 2-26; NS_YELLOW 27-31;
//     CLR_NS 32-33; EW_GREEN 34-58. Cycle period = 64.
//  2. ew_car=0, ns_car=1: ns_green holds past cycle 100.
//     Raise ew_car at cycle 100 -> ns_yellow = 1 at cycle 101.
//  3. ped_req 1-cycle pulse at cycle 4: NS_GREEN ends after cycle 11 (10 cycles);
//     yellow 12-16; CLR_NS 17-18; ped_ack + walk at 19; walk 19-26; all red 27-28;
//     EW_GREEN at 29.
//  4. ped_req pulsed during PED_WALK -> no second ped_ack; next cycle goes straight
//     to a green without another walk.
//  5. reset asserted mid EW_GREEN (ew_green=1) -> next edge: all red, phase=5,
//     walk=0; after deassert, NS_GREEN after 2 cycles.
//  6. Random sensors/ped for 10k cycles with assertions:
//     - never any non-red lamp on both approaches;
//     - walk=1 only with both reds;
//     - one lamp per approach;
//     - every ped_req is acked.

Source files
------------

// File: rtl/intersection_scheduler.sv
// intersection_scheduler: NS/EW lamp sequencer with rest-in-green and a latched pedestrian walk phase
module intersection_scheduler #(
   parameter int GREEN_TIME   = 25,
   parameter int MIN_GREEN    = 10,
   parameter int YELLOW_TIME  = 5,
   parameter int ALL_RED_TIME = 2,
   parameter int WALK_TIME    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ns_car,
   input  logic       ew_car,
   input  logic       ped_req,
   output logic       ns_red,
   output logic       ns_yellow,
   output logic       ns_green,
   output logic       ew_red,
   output logic       ew_yellow,
   output logic       ew_green,
   output logic       walk,
   output logic       ped_ack,
   output logic [2:0] phase
);
   typedef enum logic [2:0] {
      NS_GREEN, NS_YELLOW, CLR_NS, EW_GREEN, EW_YELLOW, CLR_EW, PED_WALK
   } state_t;
   localparam logic [7:0] MIN_END   = 8'(MIN_GREEN - 1);
   localparam logic [7:0] GREEN_END = 8'(GREEN_TIME - 1);
   localparam logic [7:0] YEL_END   = 8'(YELLOW_TIME - 1);
   localparam logic [7:0] CLR_END   = 8'(ALL_RED_TIME - 1);
   localparam logic [7:0] PED_END   = 8'(WALK_TIME + ALL_RED_TIME - 1);
   localparam logic [7:0] WALK_LEN  = 8'(WALK_TIME);
   state_t     state, nxt;
   logic [7:0] timer;
   logic       ped_pending, last_dir, opp_car, green_exit, ped_start;
   always_comb begin
      opp_car    = (state == NS_GREEN) ? ew_car : ns_car;
      green_exit = (ped_pending && timer >= MIN_END) ||
                   (timer >= GREEN_END && (opp_car || ped_pending));
      nxt = state;
      case (state)
         NS_GREEN:  nxt = green_exit ? NS_YELLOW : NS_GREEN;
         NS_YELLOW: nxt = (timer == YEL_END) ? CLR_NS : NS_YELLOW;
         CLR_NS:    nxt = (timer != CLR_END) ? CLR_NS : ped_pending ? PED_WALK : EW_GREEN;
         EW_GREEN:  nxt = green_exit ? EW_YELLOW : EW_GREEN;
         EW_YELLOW: nxt = (timer == YEL_END) ? CLR_EW : EW_YELLOW;
         CLR_EW:    nxt = (timer != CLR_END) ? CLR_EW : ped_pending ? PED_WALK : NS_GREEN;
         PED_WALK:  nxt = (timer != PED_END) ? PED_WALK : last_dir ? NS_GREEN : EW_GREEN;
         default:   nxt = CLR_EW;
      endcase
      ped_start = (nxt == PED_WALK) && (state != PED_WALK);
   end
   // last_dir: 0 = NS was the last served approach, 1 = EW
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= CLR_EW;
         timer       <= '0;
         ped_pending <= 1'b0;
         last_dir    <= 1'b1;
         ped_ack     <= 1'b0;
      end else begin
         state       <= nxt;
         timer       <= (nxt != state) ? '0 : (timer == 8'hff) ? timer : timer + 8'd1;
         ped_pending <= ped_start ? 1'b0 : ped_pending | (ped_req && state != PED_WALK);
         last_dir    <= (state == NS_GREEN) ? 1'b0 : (state == EW_GREEN) ? 1'b1 : last_dir;
         ped_ack     <= ped_start;
      end
   end
   assign ns_green  = state == NS_GREEN;
   assign ns_yellow = state == NS_YELLOW;
   assign ns_red    = !(ns_green || ns_yellow);
   assign ew_green  = state == EW_GREEN;
   assign ew_yellow = state == EW_YELLOW;
   assign ew_red    = !(ew_green || ew_yellow);
   assign walk      = (state == PED_WALK) && (timer < WALK_LEN);
   assign phase     = state;
endmodule

// File: tb/tb_intersection_scheduler.sv
// tb_intersection_scheduler: directed timeline checks plus a random run against a rule-level reference model
module tb_intersection_scheduler;
   localparam int GT = 25, MG = 10, YT = 5, AR = 2, WT = 8;
   logic clk = 0, reset = 1, ns_car = 0, ew_car = 0, ped_req = 0;
   logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_ack;
   logic [2:0] phase;
   int checks = 0, errors = 0, cyc = 0, acks = 0;
   int m_phase, m_age, m_last;
   bit m_ped, m_ack;
   logic rn, re, rp;
   bit pend;
   int pend_age, max_age;
   int t1_cyc[13] = '{1, 2, 26, 27, 31, 32, 33, 34, 58, 59, 63, 64, 66};
   int t1_ph[13]  = '{5, 0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 0};
   int t3_cyc[14] = '{11, 12, 16, 17, 18, 19, 20, 26, 27, 28, 29, 53, 54, 61};
   int t3_exp[14] = '{'h00, 'h04, 'h04, 'h08, 'h08, 'h1b, 'h1a, 'h1a, 'h18, 'h18, 'h0c, 'h0c, 'h10, 'h00};

   intersection_scheduler #(.GREEN_TIME(GT), .MIN_GREEN(MG), .YELLOW_TIME(YT),
                            .ALL_RED_TIME(AR), .WALK_TIME(WT)) dut (
      .clk(clk), .reset(reset), .ns_car(ns_car), .ew_car(ew_car), .ped_req(ped_req),
      .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
      .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
      .walk(walk), .ped_ack(ped_ack), .phase(phase));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: phase follows dwell-count rules; age counts whole cycles spent in the phase
   task automatic model_edge();
      int nxt;
      bit opp, enter;
      if (reset) begin
         m_phase = 5; m_age = 0; m_ped = 0; m_last = 1; m_ack = 0;
         return;
      end
      nxt = m_phase;
      case (m_phase)
         0, 3: begin
            opp = (m_phase == 0) ? ew_car : ns_car;
            if ((m_ped && m_age + 1 >= MG) || (m_age + 1 >= GT && (opp || m_ped))) nxt = m_phase + 1;
         end
         1, 4: if (m_age + 1 >= YT) nxt = m_phase + 1;
         2, 5: if (m_age + 1 >= AR) nxt = m_ped ? 6 : (m_phase == 2 ? 3 : 0);
         default: if (m_age + 1 >= WT + AR) nxt = (m_last == 0) ? 3 : 0;
      endcase
      enter = (nxt == 6) && (m_phase != 6);
      if (m_phase == 0) m_last = 0;
      else if (m_phase == 3) m_last = 1;
      m_ped = enter ? 1'b0 : (m_ped || (ped_req && m_phase != 6));
      m_ack = enter;
      m_age = (nxt == m_phase) ? m_age + 1 : 0;
      m_phase = nxt;
   endtask

   function automatic logic [10:0] expv();
      logic ng, ny, eg, ey;
      ng = m_phase == 0; ny = m_phase == 1; eg = m_phase == 3; ey = m_phase == 4;
      return {!(ng || ny), ny, ng, !(eg || ey), ey, eg, m_phase == 6 && m_age < WT, m_ack, 3'(m_phase)};
   endfunction

   function automatic logic [10:0] obsv();
      return {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_ack, phase};
   endfunction

   task automatic step(input logic ns, input logic ew, input logic ped);
      ns_car = ns; ew_car = ew; ped_req = ped;
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      chk($sformatf("model@%0d", cyc), 32'(obsv()), 32'(expv()));
      chk("exclusive_go", 32'((ns_yellow | ns_green) & (ew_yellow | ew_green)), 0);
      chk("walk_all_red", 32'(walk & !(ns_red & ew_red)), 0);
      chk("one_lamp", 32'({$countones({ns_red, ns_yellow, ns_green}) == 1,
                          $countones({ew_red, ew_yellow, ew_green}) == 1}), 3);
      if (ped_ack) acks++;
   endtask

   task automatic do_reset();
      reset = 1;
      step(0, 0, 0);
      reset = 0;
      cyc = 0;
   endtask

   initial begin
      // 1: both approaches demanding, full alternation
      do_reset();
      chk("t1_reset_phase", 32'(phase), 5);
      while (cyc < 66) begin
         step(1, 1, 0);
         for (int k = 0; k < 13; k++)
            if (cyc == t1_cyc[k]) chk($sformatf("t1_phase@%0d", cyc), 32'(phase), t1_ph[k]);
      end
      // 2: rest in NS green until EW demand appears
      do_reset();
      while (cyc < 100) step(1, 0, 0);
      chk("t2_rest_green", 32'(ns_green), 1);
      step(1, 1, 0);
      chk("t2_yellow", 32'({ns_yellow, ns_green}), 2);
      // 3+4: ped gap-out, walk timing, ignored request during walk
      do_reset();
      acks = 0;
      while (cyc < 62) begin
         step(1, 1, cyc == 4 || cyc == 22);
         for (int k = 0; k < 14; k++)
            if (cyc == t3_cyc[k])
               chk($sformatf("t3_ph_walk_ack@%0d", cyc), 32'({phase, walk, ped_ack}), t3_exp[k]);
      end
      chk("t4_single_ack", acks, 1);
      // 5: reset during EW green
      while (!ew_green && cyc < 200) step(1, 1, 0);
      chk("t5_in_ew_green", 32'(ew_green), 1);
      reset = 1;
      step(1, 1, 0);
      chk("t5_reset_outputs", 32'(obsv()), 32'(11'b100_100_00_101));
      reset = 0;
      cyc = 0;
      step(1, 1, 0);
      chk("t5_clr_ew", 32'(phase), 5);
      step(1, 1, 0);
      chk("t5_ns_green", 32'({phase, ns_green}), 1);
      // 6: random sensors and pedestrian requests
      do_reset();
      rn = 1; re = 0; pend = 0; pend_age = 0; max_age = 0;
      for (int i = 0; i < 10060; i++) begin
         if ($urandom_range(0, 15) == 0) rn = ~rn;
         if ($urandom_range(0, 15) == 0) re = ~re;
         rp = (i < 10000) && ($urandom_range(0, 39) == 0);
         if (rp && phase != 3'd6) pend = 1;
         step(rn, re, rp);
         if (ped_ack) pend = 0;
         pend_age = pend ? pend_age + 1 : 0;
         if (pend_age > max_age) max_age = pend_age;
      end
      chk("t6_all_acked", 32'(pend), 0);
      chk("t6_ack_latency", 32'(max_age < 100), 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
